// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock-qualification sequencer clocked by the free-running reference clock.
// Optional: define PLL_RST_SEQ_TIMEOUT_EN to re-pulse the PLL when lock does not arrive in time.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_AB     = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   lock_lost;

    // locked is asynchronous to refclk; only the last synchroniser stage is trusted.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        lock_lost  = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == PLL_RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
`ifdef PLL_RST_SEQ_TIMEOUT_EN
                if (locked_s) begin
                    state_next = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = RESET_PLL;
                end
`else
                cnt_next = '0;
                if (locked_s) state_next = STABLE;
`endif
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!locked_s) begin
                    state_next = RESET_PLL;
                    lock_lost  = 1'b1;
                end
            end
            default: state_next = RESET_PLL;
        endcase
        // Every state change restarts the shared counter.
        if (state_next != state) cnt_next = '0;
    end

    // Outputs are registered from the next state so ports never see decode glitches.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            pll_rst <= (state_next == RESET_PLL);
            sys_rst <= (state_next != RUN);
            ready   <= (state_next == RUN);
            if (lock_lost && (lock_loss_cnt != {CNT_W{1'b1}})) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: streak-based reference model feeding an expected queue,
// a negedge monitor comparing every cycle, plus directed latency and async-reset checks.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int CNT_W          = 8;
    localparam int W              = 3 + CNT_W;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             rst    = 1'b1;
    logic             locked = 1'b0;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC_STAGES),
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // ---------------- clock ----------------
    always #5 refclk = ~refclk;

    // ---------------- reference model ----------------
    // n: edges since reset release; p: edge on which the latest PLL pulse began.
    // streak: consecutive synced-lock edges since the PLL pulse ended; > STABLE_CYCLES means running.
    // zeros: consecutive unlocked edges spent waiting (drives the optional timeout).
    int   m_n, m_p, m_streak, m_zeros, m_losses;
    bit   m_samples[$];
    bit   m_ls, m_run, m_pll;

    always @(posedge refclk) begin
        if (rst) begin
            m_n = 0; m_p = 0; m_streak = 0; m_zeros = 0; m_losses = 0;
            m_samples.delete();
        end else begin
            m_n++;
            m_samples.push_back(locked);
            m_ls = (m_n > SYNC_STAGES) ? m_samples[m_n - 1 - SYNC_STAGES] : 1'b0;
            if (m_n - m_p <= PLL_RST_CYCLES) begin
                m_streak = 0; m_zeros = 0;
            end else if (m_streak > STABLE_CYCLES) begin
                if (!m_ls) begin
                    m_p = m_n; m_streak = 0; m_zeros = 0;
                    if (m_losses < CNT_MAX) m_losses++;
                end
            end else if (m_ls) begin
                m_streak++; m_zeros = 0;
            end else if (m_streak > 0) begin
                m_streak = 0; m_zeros = 0;
            end else begin
                m_zeros++;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
                if (m_zeros == LOCK_TIMEOUT) begin
                    m_p = m_n; m_zeros = 0;
                end
`endif
            end
            m_run = (m_streak > STABLE_CYCLES);
            m_pll = (m_n - m_p < PLL_RST_CYCLES);
            exp_q.push_back({m_pll, !m_run, m_run, CNT_W'(m_losses)});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] mon_exp, mon_got;

    always @(negedge refclk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {pll_rst, sys_rst, ready, lock_loss_cnt};
            checks++;
            if (mon_got !== mon_exp) begin
                failures++;
                $display("FAIL mon t=%0t pll_rst/sys_rst/ready/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                         $time, mon_got[W-1], mon_got[W-2], mon_got[W-3], mon_got[CNT_W-1:0],
                         mon_exp[W-1], mon_exp[W-2], mon_exp[W-3], mon_exp[CNT_W-1:0]);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge refclk);
        #2;
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_rst;
            default: return ready;
        endcase
    endfunction

    // Returns at posedge+1 of the edge on which the signal reached val (or the limit expired).
    task automatic edges_until(input int sel, input logic val, input int limit, output int edges);
        edges = 0;
        do begin
            @(posedge refclk);
            #1;
            edges++;
        end while (get_sig(sel) !== val && edges < limit);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pll_rst"}, int'(pll_rst), 1);
        check({tag, "_sys_rst"}, int'(sys_rst), 1);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_cnt"}, int'(lock_loss_cnt), 0);
    endtask

    // Asserts rst mid-cycle, checks outputs before the next edge, releases at posedge+2.
    task automatic do_reset(input string tag);
        @(posedge refclk);
        #3;
        rst    = 1'b1;
        locked = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs(tag);
        tick(2);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int e;

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        tick(3);
        check_reset_outputs("por");
        rst = 1'b0;

        // Power-up PLL pulse length.
        edges_until(0, 1'b0, 20, e);
        check("pulse_len", e, PLL_RST_CYCLES);
        #1;

        // Lock qualification latency.
        locked = 1'b1;
        edges_until(2, 1'b1, 50, e);
        check("ready_latency", e, SYNC_STAGES + 1 + STABLE_CYCLES);
        check("sys_rst_in_run", int'(sys_rst), 0);
        #1;

        // Lock loss in RUN.
        locked = 1'b0;
        edges_until(1, 1'b1, 20, e);
        check("loss_latency", e, SYNC_STAGES + 1);
        check("loss_ready", int'(ready), 0);
        check("loss_pll_rst", int'(pll_rst), 1);
        check("loss_cnt1", int'(lock_loss_cnt), 1);
        edges_until(0, 1'b0, 20, e);
        check("loss_pulse_len", e, PLL_RST_CYCLES);
        #1;

        // One-cycle glitch in STABLE restarts qualification and is not a loss.
        do_reset("pre_glitch");
        tick(PLL_RST_CYCLES + 2);
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        edges_until(2, 1'b1, 50, e);
        check("glitch_requal", e, SYNC_STAGES + 1 + STABLE_CYCLES);
        check("glitch_cnt0", int'(lock_loss_cnt), 0);
        #1;

        // Saturation of the loss counter.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            tick(1);
            locked = 1'b1;
            tick(PLL_RST_CYCLES + SYNC_STAGES + STABLE_CYCLES + 8);
        end
        check("cnt_saturated", int'(lock_loss_cnt), CNT_MAX);

        // Async reset in RUN, then in STABLE.
        check("run_before_rst", int'(ready), 1);
        do_reset("mid_run");
        tick(PLL_RST_CYCLES + 2);
        locked = 1'b1;
        tick(SYNC_STAGES + 4);
        do_reset("mid_stable");

        // Lock never arrives: single pulse, or periodic pulses with the timeout build.
        tick(1000);
        check("nolock_ready", int'(ready), 0);

        // Randomised lock waveform with occasional resets.
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rand");
            end
            locked = 1'($urandom_range(0, 1));
            if (locked) tick($urandom_range(1, 30));
            else        tick($urandom_range(1, 6));
        end

        locked = 1'b1;
        tick(30);
        @(negedge refclk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
